vga_fb_writer: RTL
==================

Name: vga_fb_writer

Overview:
- Parametrised bus-side controller for the VGA frame buffer, replacing the single-pixel, single-bit write path.
- Owns the X/Y cursor, multi-bit pixel writes with optional auto-increment, pixel read-back, and a hardware rectangle-fill engine.
- Drives frame buffer port A.
- Sits between the 8-bit processor bus and the frame buffer; the VGA signal generator on port B is not part of this block.

Parameters:
BASE_ADDR, 8'hB0, first of 8 consecutive bus addresses decoded
X_BITS, 8, X coordinate width (LSBs of frame buffer address)
Y_BITS, 7, Y coordinate width (MSBs of frame buffer address)
PIXEL_BITS, 1, bits per pixel (1..8)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
BUS_ADDR  in  8  bus address
BUS_DATA_IN  in  8  bus write data
BUS_WE  in  1  bus write strobe, one cycle per access
BUS_RE  in  1  bus read strobe
BUS_DATA_OUT  out  8  registered read data
BUS_DATA_OE  out  1  high the cycle after a decoded read
FB_ADDR  out  X_BITS+Y_BITS  frame buffer address, {Y,X}
FB_DATA_OUT  out  PIXEL_BITS  frame buffer write data
FB_WE  out  1  frame buffer write enable
FB_DATA_IN  in  PIXEL_BITS  frame buffer read data, 1-cycle synchronous read
BUSY  out  1  fill engine active
DONE_IRQ  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset: X, Y, W, H, FILL_COL, CTRL = 0; FSM = IDLE. BUS_DATA_OUT = 0, BUS_DATA_OE = 0, FB_ADDR = 0, FB_DATA_OUT = 0, FB_WE = 0, BUSY = 0, DONE_IRQ = 0.
- Reset mid-fill aborts immediately. No further FB_WE; DONE_IRQ is not pulsed.
- Write map (offset from BASE_ADDR; data truncated to register width):
  - 0 Y
  - 1 X
  - 2 PIXEL: write DATA[PIXEL_BITS-1:0] at {Y,X}
  - 3 CTRL: bit0 AUTOINC (stored); bit1 START (self-clearing, not stored)
  - 4 W
  - 5 H
  - 6 FILL_COL
  - 7 ignored
- Read map:
  - 0 Y
  - 1 X
  - 2 pixel at {Y,X}
  - 3 {6'b0, BUSY, AUTOINC}
  - 4 W
  - 5 H
  - 6 FILL_COL
  - 7 0
  - Values are zero-extended to 8 bits.
- Read timing: BUS_RE to a decoded address registers data; BUS_DATA_OUT and BUS_DATA_OE are valid the next cycle. Undecoded read leaves OE low.
- Pixel write: FB_WE is high for exactly one cycle, the cycle after the BUS_WE cycle, with FB_ADDR = {Y,X} as of the bus write cycle.
- Auto-increment: if AUTOINC=1, X <= X+1 on the same edge that registers the pixel write. On X wrap from 2^X_BITS-1 to 0, Y <= Y+1 modulo 2^Y_BITS.
- When idle, FB_ADDR follows {Y,X} registered. Pixel read-back is valid from 2 cycles after the last X/Y change.
- FSM states:
  - IDLE -> FILL: on CTRL write with START=1 while W!=0 and H!=0. Zero W or H leaves the FSM in IDLE, with no writes and no IRQ.
  - FILL: one pixel per cycle, FB_WE=1, FB_DATA_OUT=FILL_COL. Scans row-major: cx runs X..X+W-1, cy runs Y..Y+H-1. Coordinates wrap modulo 2^X_BITS / 2^Y_BITS (no clipping). Exactly W*H write cycles.
  - FILL -> IDLE: after the last pixel. DONE_IRQ pulses on the first IDLE cycle; BUSY falls the same cycle.
  - BUSY = 1 exactly while in FILL, starting the cycle after the START write.
- Fill snapshots X, Y, W, H, FILL_COL at start. The X/Y registers are unchanged by a fill.
- While BUSY:
  - All bus writes are ignored, including START and PIXEL.
  - Reads remain serviced; offset 2 returns an undefined value.
- Simultaneous BUS_WE and BUS_RE in the same cycle: both are honoured. A read of a register returns the pre-write value.

Test Plan:
1. Reset, then write Y=5, X=10, PIXEL=1 -> FB_WE high for one cycle with FB_ADDR=0x050A, FB_DATA_OUT=1; X remains 10.
2. CTRL=1 (AUTOINC), X=0xFE, Y=3, three PIXEL writes -> FB_ADDR sequence 0x03FE, 0x03FF, 0x0400; final X=1, Y=4; reading offset 1 gives 0x01.
3. X=2, Y=1, W=3, H=2, FILL_COL=1, CTRL=2 -> BUSY for 6 cycles; writes to 0x0102, 0x0103, 0x0104, 0x0202, 0x0203, 0x0204; DONE_IRQ single pulse; status read gives 0x00.
4. During the fill in scenario 3, write X=0x55 and PIXEL -> ignored; X reads back 2 after DONE_IRQ; no extra FB_WE.
5. W=0, CTRL=2 -> BUSY stays 0, no FB_WE, no DONE_IRQ. Then W=2, X=0xFF, H=1 -> writes to {Y,0xFF} then {Y,0x00}.
6. Assert RESET on the 2nd fill cycle -> FB_WE 0 from the next cycle; all registers 0; no DONE_IRQ. A read of offset 4 after reset gives 0x00 with BUS_DATA_OE one cycle after BUS_RE.

Source files
------------

// File: rtl/vga_fb_writer_if.sv
// vga_fb_writer_if: processor bus and frame buffer port A signals of vga_fb_writer.
//   slave  : the writer block (consumes bus strobes and FB read data, drives the rest)
//   master : the surrounding system (processor bus, frame buffer model, IRQ sink)
// Signals:
//   BUS_ADDR/BUS_DATA_IN/BUS_WE/BUS_RE  processor bus access
//   BUS_DATA_OUT/BUS_DATA_OE            registered read data and its valid flag
//   FB_ADDR/FB_DATA_OUT/FB_WE           frame buffer port A write side, FB_ADDR = {Y,X}
//   FB_DATA_IN                          frame buffer port A read data (1-cycle sync read)
//   BUSY/DONE_IRQ                       fill engine status and completion pulse
interface vga_fb_writer_if #(
    parameter int unsigned X_BITS     = 8,
    parameter int unsigned Y_BITS     = 7,
    parameter int unsigned PIXEL_BITS = 1
) ();
    logic [7:0]               BUS_ADDR;
    logic [7:0]               BUS_DATA_IN;
    logic                     BUS_WE;
    logic                     BUS_RE;
    logic [7:0]               BUS_DATA_OUT;
    logic                     BUS_DATA_OE;
    logic [X_BITS+Y_BITS-1:0] FB_ADDR;
    logic [PIXEL_BITS-1:0]    FB_DATA_OUT;
    logic                     FB_WE;
    logic [PIXEL_BITS-1:0]    FB_DATA_IN;
    logic                     BUSY;
    logic                     DONE_IRQ;

    modport slave (
        input  BUS_ADDR, BUS_DATA_IN, BUS_WE, BUS_RE, FB_DATA_IN,
        output BUS_DATA_OUT, BUS_DATA_OE, FB_ADDR, FB_DATA_OUT, FB_WE, BUSY, DONE_IRQ
    );

    modport master (
        output BUS_ADDR, BUS_DATA_IN, BUS_WE, BUS_RE, FB_DATA_IN,
        input  BUS_DATA_OUT, BUS_DATA_OE, FB_ADDR, FB_DATA_OUT, FB_WE, BUSY, DONE_IRQ
    );
endinterface

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: bus-side controller for the VGA frame buffer (port A).
// Holds the X/Y cursor, performs multi-bit pixel writes with optional auto-increment,
// serves pixel read-back and runs a row-major rectangle fill engine.
// Ports:
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   bus    vga_fb_writer_if.slave: 8-bit processor bus, frame buffer port A, BUSY, DONE_IRQ
// Register map (offset from BASE_ADDR):
//   0 Y, 1 X, 2 PIXEL, 3 CTRL {START, AUTOINC} / status {BUSY, AUTOINC}, 4 W, 5 H, 6 FILL_COL
module vga_fb_writer #(
    parameter logic [7:0]  BASE_ADDR  = 8'hB0,
    parameter int unsigned X_BITS     = 8,
    parameter int unsigned Y_BITS     = 7,
    parameter int unsigned PIXEL_BITS = 1
) (
    input logic             CLK,
    input logic             RESET,
    vga_fb_writer_if.slave  bus
);
    localparam int unsigned AW = X_BITS + Y_BITS;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                state_q, state_d;
    logic [X_BITS-1:0]     x_q, x_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    logic [X_BITS-1:0]     w_q, w_d;
    logic [Y_BITS-1:0]     h_q, h_d;
    logic [PIXEL_BITS-1:0] fill_col_q, fill_col_d;
    logic                  autoinc_q, autoinc_d;
    logic [X_BITS-1:0]     col_rem_q, col_rem_d;
    logic [Y_BITS-1:0]     row_rem_q, row_rem_d;
    logic [AW-1:0]         fb_addr_q, fb_addr_d;
    logic [PIXEL_BITS-1:0] fb_data_q, fb_data_d;
    logic                  fb_we_q, fb_we_d;
    logic                  done_q, done_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_oe_q, rd_oe_d;

    logic [7:0]        offset;
    logic              hit;
    logic [2:0]        off;
    logic              busy;
    logic              wr_en;
    logic              rd_en;
    logic [7:0]        rd_val;
    logic [X_BITS-1:0] x_inc;
    logic [Y_BITS-1:0] y_inc;
    logic [X_BITS-1:0] cx_inc;
    logic [Y_BITS-1:0] cy_inc;

    // Subtraction-based decode so BASE_ADDR need not be 8-aligned.
    assign offset = bus.BUS_ADDR - BASE_ADDR;
    assign hit    = (offset < 8'd8);
    assign off    = offset[2:0];
    assign busy   = (state_q == StFill);
    assign wr_en  = bus.BUS_WE && hit && !busy;
    assign rd_en  = bus.BUS_RE && hit;

    assign x_inc  = x_q + 1'b1;
    assign y_inc  = y_q + 1'b1;
    assign cx_inc = fb_addr_q[X_BITS-1:0] + 1'b1;
    assign cy_inc = fb_addr_q[AW-1:X_BITS] + 1'b1;

    // Read mux works on current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_val = '0;
        unique case (off)
            3'd0: rd_val[Y_BITS-1:0]     = y_q;
            3'd1: rd_val[X_BITS-1:0]     = x_q;
            3'd2: rd_val[PIXEL_BITS-1:0] = bus.FB_DATA_IN;
            3'd3: rd_val[1:0]            = {busy, autoinc_q};
            3'd4: rd_val[X_BITS-1:0]     = w_q;
            3'd5: rd_val[Y_BITS-1:0]     = h_q;
            3'd6: rd_val[PIXEL_BITS-1:0] = fill_col_q;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        fill_col_d = fill_col_q;
        autoinc_d  = autoinc_q;
        col_rem_d  = col_rem_q;
        row_rem_d  = row_rem_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_we_d    = 1'b0;
        done_d     = 1'b0;
        rd_oe_d    = rd_en;
        rd_data_d  = rd_en ? rd_val : rd_data_q;

        unique case (state_q)
            StIdle: begin
                fb_addr_d = {y_q, x_q};
                if (wr_en) begin
                    unique case (off)
                        3'd0: y_d = bus.BUS_DATA_IN[Y_BITS-1:0];
                        3'd1: x_d = bus.BUS_DATA_IN[X_BITS-1:0];
                        3'd2: begin
                            fb_we_d   = 1'b1;
                            fb_data_d = bus.BUS_DATA_IN[PIXEL_BITS-1:0];
                            if (autoinc_q) begin
                                x_d = x_inc;
                                if (x_q == '1) begin
                                    y_d = y_inc;
                                end
                            end
                        end
                        3'd3: begin
                            autoinc_d = bus.BUS_DATA_IN[0];
                            if (bus.BUS_DATA_IN[1] && (w_q != '0) && (h_q != '0)) begin
                                // First fill pixel is issued on the entry edge so that
                                // FB_WE covers every BUSY cycle.
                                state_d   = StFill;
                                fb_we_d   = 1'b1;
                                fb_data_d = fill_col_q;
                                col_rem_d = w_q - 1'b1;
                                row_rem_d = h_q - 1'b1;
                            end
                        end
                        3'd4: w_d        = bus.BUS_DATA_IN[X_BITS-1:0];
                        3'd5: h_d        = bus.BUS_DATA_IN[Y_BITS-1:0];
                        3'd6: fill_col_d = bus.BUS_DATA_IN[PIXEL_BITS-1:0];
                        default: ;
                    endcase
                end
            end
            StFill: begin
                // Bus writes are locked out while filling, so x_q/w_q still hold the
                // values captured at START and serve as the fill snapshot.
                if (col_rem_q != '0) begin
                    fb_we_d                   = 1'b1;
                    fb_addr_d[X_BITS-1:0]     = cx_inc;
                    col_rem_d                 = col_rem_q - 1'b1;
                end else if (row_rem_q != '0) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {cy_inc, x_q};
                    col_rem_d = w_q - 1'b1;
                    row_rem_d = row_rem_q - 1'b1;
                end else begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    fb_addr_d = {y_q, x_q};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            fill_col_q <= '0;
            autoinc_q  <= 1'b0;
            col_rem_q  <= '0;
            row_rem_q  <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_we_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            fill_col_q <= fill_col_d;
            autoinc_q  <= autoinc_d;
            col_rem_q  <= col_rem_d;
            row_rem_q  <= row_rem_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_we_q    <= fb_we_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_oe_q    <= rd_oe_d;
        end
    end

    assign bus.FB_ADDR      = fb_addr_q;
    assign bus.FB_DATA_OUT  = fb_data_q;
    assign bus.FB_WE        = fb_we_q;
    assign bus.BUSY         = busy;
    assign bus.DONE_IRQ     = done_q;
    assign bus.BUS_DATA_OUT = rd_data_q;
    assign bus.BUS_DATA_OE  = rd_oe_q;
endmodule
